// File: rtl/pyramid_frame_scheduler.sv
// Frame sequencer: starts one of four pixel sources per frame request,
// forwards its stream for N_PIXEL beats, then pulses frame_done.
// Ports:
//   clock, reset                async active-high reset
//   frame_start/_ack            level request in, 1-cycle accept pulse out
//   mode_sel, auto_cycle        manual source index / round-robin enable
//   src_start/_ack              one-hot start handshake to the sources
//   src_valid, src_pixel        four 8-bit pixel streams, {s3,s2,s1,s0}
//   video, video_valid          forwarded stream, 1-cycle latency
//   frame_done                  1-cycle pulse after the last pixel
//   cur_src                     source latched for the current frame
//   err_timeout                 sticky start-ack timeout flag
module pyramid_frame_scheduler #(
  parameter int N_PIXEL        = 480000,
  parameter int CNT_W          = 19,
  parameter int FRAMES_PER_SRC = 60,
  parameter int ACK_TIMEOUT    = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_start,
  output logic        frame_start_ack,
  input  logic [1:0]  mode_sel,
  input  logic        auto_cycle,
  output logic [3:0]  src_start,
  input  logic [3:0]  src_start_ack,
  input  logic [3:0]  src_valid,
  input  logic [31:0] src_pixel,
  output logic [7:0]  video,
  output logic        video_valid,
  output logic        frame_done,
  output logic [1:0]  cur_src,
  output logic        err_timeout
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int DW = $clog2(FRAMES_PER_SRC) + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    STREAM,
    DONE
  } state_t;

  state_t          state;
  logic [1:0]      rr_idx;
  logic [DW-1:0]   dwell;
  logic [CNT_W-1:0] pix_cnt;
  logic [TW-1:0]   timer;

  logic [1:0] next_src;
  logic       sel_ack;
  logic       sel_valid;
  logic [7:0] sel_pixel;

  assign next_src  = auto_cycle ? rr_idx : mode_sel;
  assign sel_ack   = src_start_ack[cur_src];
  assign sel_valid = src_valid[cur_src];
  assign sel_pixel = src_pixel[{cur_src, 3'b000} +: 8];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      frame_start_ack <= 1'b0;
      src_start       <= 4'b0000;
      video           <= 8'h00;
      video_valid     <= 1'b0;
      frame_done      <= 1'b0;
      cur_src         <= 2'd0;
      err_timeout     <= 1'b0;
      rr_idx          <= 2'd0;
      dwell           <= '0;
      pix_cnt         <= '0;
      timer           <= '0;
    end else begin
      frame_start_ack <= 1'b0;
      frame_done      <= 1'b0;
      unique case (state)
        IDLE: begin
          video_valid <= 1'b0;
          if (frame_start) begin
            cur_src   <= next_src;
            timer     <= '0;
            pix_cnt   <= '0;
            src_start <= 4'b0001 << next_src;
            state     <= REQ;
          end
        end
        REQ: begin
          if (sel_ack) begin
            src_start       <= 4'b0000;
            frame_start_ack <= 1'b1;
            state           <= STREAM;
          end else if (timer == TW'(ACK_TIMEOUT)) begin
            err_timeout <= 1'b1;
            src_start   <= 4'b0000;
            state       <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        STREAM: begin
          video       <= sel_pixel;
          video_valid <= sel_valid;
          if (sel_valid) begin
            pix_cnt <= pix_cnt + CNT_W'(1);
            if (pix_cnt == CNT_W'(N_PIXEL - 1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          video_valid <= 1'b0;
          frame_done  <= 1'b1;
          if (auto_cycle) begin
            if (dwell == DW'(FRAMES_PER_SRC - 1)) begin
              dwell  <= '0;
              rr_idx <= rr_idx + 2'd1;
            end else begin
              dwell <= dwell + DW'(1);
            end
          end else begin
            dwell <= '0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pyramid_frame_scheduler.sv
// Randomized scoreboard bench for pyramid_frame_scheduler.
// Small frames (16 px), dwell of 2 frames, ack timeout of 8 cycles.
module tb_pyramid_frame_scheduler;

  localparam int NP  = 16;
  localparam int FPS = 2;
  localparam int TO  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        frame_start_ack;
  logic [1:0]  mode_sel;
  logic        auto_cycle;
  logic [3:0]  src_start;
  logic [3:0]  src_start_ack;
  logic [3:0]  src_valid;
  logic [31:0] src_pixel;
  logic [7:0]  video;
  logic        video_valid;
  logic        frame_done;
  logic [1:0]  cur_src;
  logic        err_timeout;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q[$];
  int rr    = 0;
  int dwell = 0;

  always #5 clk = ~clk;

  pyramid_frame_scheduler #(
    .N_PIXEL(NP),
    .CNT_W(5),
    .FRAMES_PER_SRC(FPS),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clock(clk),
    .reset(rst),
    .frame_start(frame_start),
    .frame_start_ack(frame_start_ack),
    .mode_sel(mode_sel),
    .auto_cycle(auto_cycle),
    .src_start(src_start),
    .src_start_ack(src_start_ack),
    .src_valid(src_valid),
    .src_pixel(src_pixel),
    .video(video),
    .video_valid(video_valid),
    .frame_done(frame_done),
    .cur_src(cur_src),
    .err_timeout(err_timeout)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every forwarded beat must be the next expected
  // pixel of the selected source.
  always @(negedge clk) begin
    if (!rst && video_valid) begin
      if (q.size() == 0) begin
        chk("video_unexpected_beat", {24'h0, video}, 32'hFFFF_FFFF);
      end else begin
        chk("video_pixel", {24'h0, video}, {24'h0, q.pop_front()});
      end
    end
  end

  function automatic logic [3:0] onehot(input logic [1:0] s);
    logic [3:0] r;
    r = 4'b0000;
    r[s] = 1'b1;
    return r;
  endfunction

  // One frame: request, ack after ack_dly REQ cycles, stream NP beats.
  // pat 0 = random gaps, pat 1 = alternating valid.
  task automatic run_frame(input logic [1:0] ms, input logic au,
                           input int ack_dly, input int pat,
                           input bit others_all, input bit extra,
                           input bit keep_fs, input int abort_at);
    logic [1:0] es;
    logic [3:0] sv;
    logic [31:0] px;
    logic [7:0] p;
    logic v;
    logic prev_v;
    int beats;
    int cyc;
    es = au ? 2'(rr) : ms;
    mode_sel    = ms;
    auto_cycle  = au;
    frame_start = 1'b1;
    tick();
    for (int i = 0; i <= ack_dly; i++) begin
      mode_sel      = 2'($urandom_range(0, 3));
      src_valid     = 4'($urandom_range(0, 15));
      src_start_ack = 4'($urandom_range(0, 15)) & ~onehot(es);
      if (i == ack_dly) src_start_ack = src_start_ack | onehot(es);
      @(negedge clk);
      chk("src_start_req", {28'h0, src_start}, {28'h0, onehot(es)});
      chk("cur_src_latched", {30'h0, cur_src}, {30'h0, es});
      chk("no_ack_in_req", {31'h0, frame_start_ack}, 32'h0);
      chk("no_valid_in_req", {31'h0, video_valid}, 32'h0);
      tick();
    end
    src_start_ack = 4'b0000;
    if (!keep_fs) frame_start = 1'b0;
    beats  = 0;
    cyc    = 0;
    prev_v = 1'b0;
    while (beats < NP) begin
      v  = (pat == 1) ? ((cyc % 2) == 0) : ($urandom_range(0, 3) != 0);
      sv = others_all ? 4'hF : 4'($urandom_range(0, 15));
      sv[es] = v;
      px = {4{8'hAA}};
      p  = 8'($urandom_range(0, 255));
      px[{es, 3'b000} +: 8] = p;
      src_valid = sv;
      src_pixel = px;
      mode_sel  = 2'($urandom_range(0, 3));
      if (v) begin
        q.push_back(p);
        beats++;
      end
      @(negedge clk);
      chk("ack_pulse", {31'h0, frame_start_ack}, {31'h0, cyc == 0});
      chk("video_latency", {31'h0, video_valid}, {31'h0, prev_v});
      if (cyc == 0) chk("src_start_dropped", {28'h0, src_start}, 32'h0);
      chk("no_early_done", {31'h0, frame_done}, 32'h0);
      prev_v = v;
      tick();
      cyc++;
      if (abort_at != 0 && beats == abort_at) return;
    end
    // DONE cycle: any further valid from the source must be dropped.
    sv = 4'($urandom_range(0, 15));
    sv[es] = extra;
    src_valid = sv;
    @(negedge clk);
    chk("last_beat_valid", {31'h0, video_valid}, 32'h1);
    chk("done_not_yet", {31'h0, frame_done}, 32'h0);
    tick();
    src_valid = 4'b0000;
    @(negedge clk);
    chk("frame_done_pulse", {31'h0, frame_done}, 32'h1);
    chk("valid_after_done", {31'h0, video_valid}, 32'h0);
    chk("cur_src_frame", {30'h0, cur_src}, {30'h0, es});
    chk("queue_drained", q.size(), 32'h0);
    if (au) begin
      dwell++;
      if (dwell == FPS) begin
        dwell = 0;
        rr = (rr + 1) % 4;
      end
    end else begin
      dwell = 0;
    end
  endtask

  task automatic timeout_req(input logic [1:0] ms);
    mode_sel    = ms;
    auto_cycle  = 1'b0;
    frame_start = 1'b1;
    tick();
    for (int i = 0; i <= TO; i++) begin
      src_start_ack = 4'($urandom_range(0, 15)) & ~onehot(ms);
      @(negedge clk);
      chk("to_src_start", {28'h0, src_start}, {28'h0, onehot(ms)});
      chk("to_err_low", {31'h0, err_timeout}, 32'h0);
      tick();
    end
    frame_start   = 1'b0;
    src_start_ack = 4'b0000;
    @(negedge clk);
    chk("to_err_set", {31'h0, err_timeout}, 32'h1);
    chk("to_src_start_off", {28'h0, src_start}, 32'h0);
    chk("to_no_ack", {31'h0, frame_start_ack}, 32'h0);
    tick();
    @(negedge clk);
    chk("to_no_ack_late", {31'h0, frame_start_ack}, 32'h0);
  endtask

  initial begin
    rst           = 1'b1;
    frame_start   = 1'b0;
    mode_sel      = 2'd0;
    auto_cycle    = 1'b0;
    src_start_ack = 4'b0000;
    src_valid     = 4'b0000;
    src_pixel     = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_src_start", {28'h0, src_start}, 32'h0);
    chk("rst_video", {24'h0, video}, 32'h0);
    chk("rst_video_valid", {31'h0, video_valid}, 32'h0);
    chk("rst_frame_done", {31'h0, frame_done}, 32'h0);
    chk("rst_cur_src", {30'h0, cur_src}, 32'h0);
    chk("rst_err", {31'h0, err_timeout}, 32'h0);
    chk("rst_ack", {31'h0, frame_start_ack}, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // src1 with 3-cycle ack delay, other sources flooding 0xAA
    run_frame(2'd1, 1'b0, 3, 0, 1'b1, 1'b0, 1'b0, 0);

    // start request nobody acknowledges, then a normal frame
    timeout_req(2'd2);
    run_frame(2'd2, 1'b0, int'($urandom_range(0, 7)), 0, 1'b0, 1'b0, 1'b0, 0);
    chk("err_sticky", {31'h0, err_timeout}, 32'h1);

    // auto rotation over 9 back-to-back frames
    for (int f = 0; f < 9; f++) begin
      run_frame(2'($urandom_range(0, 3)), 1'b1, int'($urandom_range(0, 7)),
                0, 1'b0, 1'b0, f != 8, 0);
    end

    // alternating valid and a 17th beat that must be dropped
    run_frame(2'd1, 1'b0, 2, 1, 1'b0, 1'b1, 1'b0, 0);

    // a few random manual frames
    for (int f = 0; f < 4; f++) begin
      run_frame(2'($urandom_range(0, 3)), 1'b0, int'($urandom_range(0, 7)),
                0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 0);
    end

    // reset in the middle of a frame
    run_frame(2'd3, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 7);
    rst = 1'b1;
    q.delete();
    rr    = 0;
    dwell = 0;
    src_valid = 4'b0000;
    #1;
    chk("abort_video_valid", {31'h0, video_valid}, 32'h0);
    chk("abort_video", {24'h0, video}, 32'h0);
    chk("abort_cur_src", {30'h0, cur_src}, 32'h0);
    chk("abort_err", {31'h0, err_timeout}, 32'h0);
    chk("abort_src_start", {28'h0, src_start}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", {31'h0, frame_done}, 32'h0);
    end
    frame_start = 1'b1;
    auto_cycle  = 1'b1;
    mode_sel    = 2'd3;
    tick();
    rst = 1'b0;
    run_frame(2'd3, 1'b1, 2, 0, 1'b0, 1'b0, 1'b0, 0);

    repeat (3) @(posedge clk);
    chk("final_queue_empty", q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
